// File: rtl/soc_system_pio_pkg.sv
// Shared register map and edge-select encodings for the HPS control PIOs (input and output side).
// Pure definitions: no latency, no backpressure.
package soc_system_pio_pkg;

    localparam logic [2:0] REG_DATA    = 3'd0;
    localparam logic [2:0] REG_DIR     = 3'd1;
    localparam logic [2:0] REG_IRQMASK = 3'd2;
    localparam logic [2:0] REG_EDGECAP = 3'd3;
    localparam logic [2:0] REG_OUTSET  = 3'd4;
    localparam logic [2:0] REG_OUTCLR  = 3'd5;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // One Avalon-MM slave access as seen in a single clock cycle.
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdat;
    } avs_req_t;

endpackage

// File: rtl/soc_system_pio_debounce.sv
// Single-bit synchroniser plus optional stability filter for one external status line.
// Latency SYNC_STAGES (+DEBOUNCE_CYCLES when enabled); no backpressure, samples every cycle.
module soc_system_pio_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    output logic d_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign d_o = s;
        end else begin : g_filter
            localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             deb_q, deb_d;

            // The new level is accepted only after s has disagreed with d for DEBOUNCE_CYCLES cycles.
            always_comb begin
                cnt_d = cnt_q;
                deb_d = deb_q;
                if (s == deb_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d = s;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                    deb_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    deb_q <= deb_d;
                end
            end

            assign d_o = deb_q;
        end
    endgenerate

endmodule

// File: rtl/soc_system_status_in_pio.sv
// Avalon-MM input PIO: synchronised status lines, edge capture with W1C, maskable level IRQ.
// Read latency 1; pin->irq SYNC_STAGES+DEBOUNCE_CYCLES+2; no waitrequest, always accepts.
module soc_system_status_in_pio
    import soc_system_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 0,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Hold off capture until the reset-time input level has propagated through the filter,
    // so a line already high at reset release never looks like a fresh edge.
    localparam int ARM_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
    localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

    avs_req_t         req;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] edge_w;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic             armed;
    logic [31:0]      rd_mux;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             unused_wdata;

    assign req.rd   = chipselect & ~read_n;
    assign req.wr   = chipselect & ~write_n;
    assign req.addr = address;
    assign req.wdat = writedata;

    assign unused_wdata = ^writedata;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            soc_system_pio_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_deb (
                .clk     (clk),
                .reset_n (reset_n),
                .in_i    (in_port[i]),
                .d_o     (deb_d[i])
            );
        end
    endgenerate

    assign armed = (arm_cnt_q == ARM_W'(ARM_CYCLES));

    always_comb begin
        edge_w = deb_d & ~prev_q;
        if (EDGE_TYPE == EDGE_FALLING) begin
            edge_w = ~deb_d & prev_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_w = deb_d ^ prev_q;
        end
    end

    always_comb begin
        arm_cnt_d = arm_cnt_q;
        if (!armed) begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end

        irq_mask_d = irq_mask_q;
        if (req.wr && req.addr == REG_IRQMASK) begin
            irq_mask_d = req.wdat[WIDTH-1:0];
        end

        w1c = '0;
        if (req.wr && req.addr == REG_EDGECAP) begin
            w1c = req.wdat[WIDTH-1:0];
        end

        // Set after clear: an edge landing on the W1C cycle is kept.
        edge_cap_d = (edge_cap_q & ~w1c) | (armed ? edge_w : '0);

        irq_d = |(edge_cap_q & irq_mask_q);

        rd_mux = '0;
        case (req.addr)
            REG_DATA:    rd_mux[WIDTH-1:0] = deb_d;
            REG_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask_q;
            REG_EDGECAP: rd_mux[WIDTH-1:0] = edge_cap_q;
            default:     rd_mux = '0;
        endcase

        readdata_d = req.rd ? rd_mux : readdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            arm_cnt_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= deb_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            arm_cnt_q  <= arm_cnt_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_soc_system_status_in_pio.sv
// Directed bench for the input PIO: three instances (plain rising, debounced, any-edge) on one bus.
// Inputs driven and outputs sampled 1 time unit after the rising clock edge.
module tb_soc_system_status_in_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in0, in1, in2;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    soc_system_status_in_pio #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .in_port(in0), .readdata(rd0), .irq(irq0));

    soc_system_status_in_pio #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .in_port(in1), .readdata(rd1), .irq(irq1));

    soc_system_status_in_pio #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .in_port(in2), .readdata(rd2), .irq(irq2));

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a);
        address    = a;
        chipselect = 1'b1;
        read_n     = 1'b0;
        tick();
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in0 = 8'hFF; in1 = 8'h00; in2 = 8'h00;
        tick(3);
        n_cmp++; if (rd0 !== 32'h0) begin n_err++; $display("FAIL reset_readdata got %h want %h", rd0, 32'h0); end
        n_cmp++; if (irq0 !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", irq0); end
        reset_n = 1'b1;
        tick(6);
        bus_read(3'd0);
        n_cmp++; if (rd0 !== 32'hFF) begin n_err++; $display("FAIL reset_data got %h want %h", rd0, 32'hFF); end
        bus_read(3'd3);
        n_cmp++; if (rd0 !== 32'h0) begin n_err++; $display("FAIL reset_edgecap got %h want %h", rd0, 32'h0); end
        n_cmp++; if (irq0 !== 1'b0) begin n_err++; $display("FAIL reset_irq_after got %b want 0", irq0); end
    endtask

    task automatic test_edge_irq();
        in0 = 8'h00;
        tick(6);
        bus_write(3'd2, 32'h01);
        in0 = 8'h01;
        tick(3);
        n_cmp++; if (irq0 !== 1'b0) begin n_err++; $display("FAIL edge_irq_early got %b want 0", irq0); end
        tick();
        n_cmp++; if (irq0 !== 1'b1) begin n_err++; $display("FAIL edge_irq_latency got %b want 1", irq0); end
        bus_read(3'd3);
        n_cmp++; if (rd0 !== 32'h01) begin n_err++; $display("FAIL edge_cap_bit0 got %h want %h", rd0, 32'h01); end
        bus_write(3'd3, 32'h01);
        n_cmp++; if (irq0 !== 1'b1) begin n_err++; $display("FAIL w1c_irq_lag got %b want 1", irq0); end
        tick();
        n_cmp++; if (irq0 !== 1'b0) begin n_err++; $display("FAIL w1c_irq_clear got %b want 0", irq0); end
        bus_read(3'd3);
        n_cmp++; if (rd0 !== 32'h0) begin n_err++; $display("FAIL w1c_edgecap got %h want %h", rd0, 32'h0); end
    endtask

    task automatic test_set_wins();
        in0 = 8'h05;
        tick(2);
        bus_write(3'd3, 32'h04);
        bus_read(3'd3);
        n_cmp++; if (rd0 !== 32'h04) begin n_err++; $display("FAIL set_wins got %h want %h", rd0, 32'h04); end
        bus_write(3'd3, 32'h00);
        bus_read(3'd3);
        n_cmp++; if (rd0 !== 32'h04) begin n_err++; $display("FAIL w1c_zero_noop got %h want %h", rd0, 32'h04); end
        bus_read(3'd3);
        n_cmp++; if (rd0 !== 32'h04) begin n_err++; $display("FAIL read_no_clear got %h want %h", rd0, 32'h04); end
        n_cmp++; if (irq0 !== 1'b0) begin n_err++; $display("FAIL masked_irq got %b want 0", irq0); end
        bus_write(3'd3, 32'h04);
        bus_read(3'd3);
        n_cmp++; if (rd0 !== 32'h0) begin n_err++; $display("FAIL w1c_bit2 got %h want %h", rd0, 32'h0); end
    endtask

    task automatic test_debounce();
        in1 = 8'h02;
        tick(3);
        in1 = 8'h00;
        tick(10);
        bus_read(3'd0);
        n_cmp++; if (rd1 !== 32'h0) begin n_err++; $display("FAIL glitch_data got %h want %h", rd1, 32'h0); end
        bus_read(3'd3);
        n_cmp++; if (rd1 !== 32'h0) begin n_err++; $display("FAIL glitch_edgecap got %h want %h", rd1, 32'h0); end
        in1 = 8'h02;
        tick(5);
        in1 = 8'h00;
        tick(12);
        bus_read(3'd3);
        n_cmp++; if (rd1 !== 32'h02) begin n_err++; $display("FAIL pulse_edgecap got %h want %h", rd1, 32'h02); end
        bus_read(3'd0);
        n_cmp++; if (rd1 !== 32'h0) begin n_err++; $display("FAIL pulse_data_settled got %h want %h", rd1, 32'h0); end
        in1 = 8'h02;
        tick(10);
        bus_read(3'd0);
        n_cmp++; if (rd1 !== 32'h02) begin n_err++; $display("FAIL held_data got %h want %h", rd1, 32'h02); end
    endtask

    task automatic test_any_edge();
        bus_write(3'd2, 32'h00);
        in2 = 8'h08;
        tick(3);
        in2 = 8'h00;
        tick(8);
        bus_read(3'd3);
        n_cmp++; if (rd2 !== 32'h08) begin n_err++; $display("FAIL any_edgecap got %h want %h", rd2, 32'h08); end
        n_cmp++; if (irq2 !== 1'b0) begin n_err++; $display("FAIL any_irq_masked got %b want 0", irq2); end
        bus_write(3'd2, 32'h08);
        n_cmp++; if (irq2 !== 1'b0) begin n_err++; $display("FAIL any_irq_lag got %b want 0", irq2); end
        tick();
        n_cmp++; if (irq2 !== 1'b1) begin n_err++; $display("FAIL any_irq_unmask got %b want 1", irq2); end
        bus_write(3'd3, 32'h08);
        in2 = 8'h08;
        tick(8);
        bus_write(3'd3, 32'h08);
        bus_read(3'd3);
        n_cmp++; if (rd2 !== 32'h0) begin n_err++; $display("FAIL any_cleared got %h want %h", rd2, 32'h0); end
        in2 = 8'h00;
        tick(8);
        bus_read(3'd3);
        n_cmp++; if (rd2 !== 32'h08) begin n_err++; $display("FAIL any_falling got %h want %h", rd2, 32'h08); end
    endtask

    task automatic test_rw_collision();
        address    = 3'd2;
        writedata  = 32'h33;
        chipselect = 1'b1;
        read_n     = 1'b0;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        n_cmp++; if (rd0 !== 32'h08) begin n_err++; $display("FAIL rw_pre_write got %h want %h", rd0, 32'h08); end
        bus_read(3'd2);
        n_cmp++; if (rd0 !== 32'h33) begin n_err++; $display("FAIL rw_write_took got %h want %h", rd0, 32'h33); end
        bus_write(3'd2, 32'hFFFF_FF5A);
        bus_read(3'd2);
        n_cmp++; if (rd0 !== 32'h5A) begin n_err++; $display("FAIL mask_upper_ignored got %h want %h", rd0, 32'h5A); end
        tick(3);
        n_cmp++; if (rd0 !== 32'h5A) begin n_err++; $display("FAIL readdata_hold got %h want %h", rd0, 32'h5A); end
    endtask

    task automatic test_reset_mid();
        logic [2:0] unused_addrs [5];
        unused_addrs = '{3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        in0 = 8'h00;
        tick(5);
        in0 = 8'h0F;
        tick(5);
        bus_write(3'd2, 32'h0F);
        tick(2);
        n_cmp++; if (irq0 !== 1'b1) begin n_err++; $display("FAIL pre_reset_irq got %b want 1", irq0); end
        bus_read(3'd3);
        n_cmp++; if (rd0 !== 32'h0F) begin n_err++; $display("FAIL pre_reset_edgecap got %h want %h", rd0, 32'h0F); end
        for (int j = 0; j < 5; j++) begin
            bus_read(unused_addrs[j]);
            n_cmp++; if (rd0 !== 32'h0) begin n_err++; $display("FAIL unused_addr%0d got %h want %h", unused_addrs[j], rd0, 32'h0); end
        end
        bus_read(3'd3);
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (rd0 !== 32'h0) begin n_err++; $display("FAIL async_reset_readdata got %h want %h", rd0, 32'h0); end
        n_cmp++; if (irq0 !== 1'b0) begin n_err++; $display("FAIL async_reset_irq got %b want 0", irq0); end
        tick(2);
        reset_n = 1'b1;
        tick(8);
        bus_read(3'd3);
        n_cmp++; if (rd0 !== 32'h0) begin n_err++; $display("FAIL post_reset_edgecap got %h want %h", rd0, 32'h0); end
        bus_read(3'd2);
        n_cmp++; if (rd0 !== 32'h0) begin n_err++; $display("FAIL post_reset_mask got %h want %h", rd0, 32'h0); end
        bus_read(3'd0);
        n_cmp++; if (rd0 !== 32'h0F) begin n_err++; $display("FAIL post_reset_data got %h want %h", rd0, 32'h0F); end
        n_cmp++; if (irq0 !== 1'b0) begin n_err++; $display("FAIL post_reset_irq got %b want 0", irq0); end
    endtask

    initial begin
        address    = 3'd0;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        writedata  = 32'h0;
        test_reset();
        test_edge_irq();
        test_set_wins();
        test_debounce();
        test_any_edge();
        test_rw_collision();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
